// File: rtl/serial_add_pkg.sv
// ============================================================================
// Module   : serial_add_pkg
// Purpose  : Shared types and helpers for the bit-serial adder controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH-1; one spare bit keeps WIDTH=1 at a legal 1-bit width.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fa_cell.sv
// ============================================================================
// Module   : fa_cell
// Purpose  : Purely combinational 1-bit full adder cell.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Sequences one fa_cell over WIDTH cycles (LSB first) between two
//            valid/ready handshakes. Optional SERIAL_ADD_OVF_EN adds port ovf.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sigma,
  output logic             c_out
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sigma;
  logic             r_carry;
  logic             r_cout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_s;
  logic             w_co;
  logic             w_accept;
  logic             w_last;

  fa_cell u_fa (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_cnt == c_last);

  // Result enters at the MSB so it is fully aligned after WIDTH shifts.
  always_comb begin
    w_res_next            = r_res >> 1;
    w_res_next[WIDTH-1]   = w_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_sigma <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= a;
      r_b     <= b;
      r_carry <= c_in;
    end else if (r_state == RUN) begin
      r_cnt   <= r_cnt + 1'b1;
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= w_res_next;
      r_carry <= w_co;
      if (w_last) begin
        r_sigma <= w_res_next;
        r_cout  <= w_co;
      end
    end
  end

  assign sigma = r_sigma;
  assign c_out = r_cout;

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the last bit the carry register holds the carry into the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_co;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl against an arithmetic model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sigma;
  logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sigma     (sigma),
    .c_out     (c_out)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic and signed range test.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int sx, sy, t;
    sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
    sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
    t  = sx + sy + int'(ci);
    return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
  endfunction

  // One full transaction; junk keeps in_valid high with random operands while busy.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input int bp, input bit junk);
    logic [W:0] exp_s;
    logic       exp_o;
    exp_s = ref_sum(xa, xb, xc);
    exp_o = ref_ovf(xa, xb, xc);
    chk("in_ready_idle", in_ready, 1'b1);
    in_valid = 1'b1; a = xa; b = xb; c_in = xc; out_ready = 1'b0;
    tick();
    for (int i = 1; i <= W; i++) begin
      if (junk) begin
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
      end else begin
        in_valid = 1'b0; a = W'($urandom); b = W'($urandom);
      end
      if (i < W) begin
        chk("out_valid_run", out_valid, 1'b0);
        chk("in_ready_run", in_ready, 1'b0);
        tick();
      end else begin
        tick();
      end
    end
    chk("out_valid_done", out_valid, 1'b1);
    chk("sigma", sigma, exp_s[W-1:0]);
    chk("c_out", c_out, exp_s[W]);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", ovf, exp_o);
`else
    if (exp_o) begin end
`endif
    for (int k = 0; k < bp; k++) begin
      tick();
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_in_ready", in_ready, 1'b0);
      chk("hold_sigma", sigma, exp_s[W-1:0]);
      chk("hold_c_out", c_out, exp_s[W]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("out_valid_after", out_valid, 1'b0);
    chk("in_ready_after", in_ready, 1'b1);
    chk("sigma_kept", sigma, exp_s[W-1:0]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sigma", sigma, '0);
    chk("rst_c_out", c_out, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", ovf, 1'b0);
`endif
    rst = 1'b0;
    tick();

    do_op(8'h5A, 8'h33, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
    do_op(8'h12, 8'h34, 1'b1, 5, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b0, 0, 1'b1);
    do_op(8'h01, 8'hC3, 1'b1, 2, 1'b1);

    // Abort in the middle of RUN: no result must appear afterwards.
    in_valid = 1'b1; a = 8'hEE; b = 8'h77; c_in = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_sigma", sigma, '0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      chk("abort_quiet", out_valid, 1'b0);
    end
    do_op(8'h10, 8'h20, 1'b0, 0, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
`endif

    for (int n = 0; n < 40; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
